// File: rtl/alu_cdb_sched.sv
// alu_cdb_sched: issue-to-writeback scheduler for the integer ALU lanes.
// Each lane evaluates its issued op on its own alu instance and parks the
// result in a one-entry register. Parked results are arbitrated
// round-robin onto the CDB ports. Issue is back-pressured while a lane's
// result waits for a port.
// Optional build macro ALU_CDB_SCHED_PERF_EN adds the stall-cycle and
// broadcast-count performance counters.

// Combinational integer ALU; shifts use opb[4:0], unknown opcodes return a marker.
module alu #(
   parameter int XLEN   = 32,
   parameter int FUNC_W = 4
) (
   input  logic [XLEN-1:0]   opa_i,
   input  logic [XLEN-1:0]   opb_i,
   input  logic [FUNC_W-1:0] func_i,
   output logic [XLEN-1:0]   result_o
);

   localparam logic [FUNC_W-1:0] FN_ADD  = FUNC_W'(0);
   localparam logic [FUNC_W-1:0] FN_SUB  = FUNC_W'(1);
   localparam logic [FUNC_W-1:0] FN_SLT  = FUNC_W'(2);
   localparam logic [FUNC_W-1:0] FN_SLTU = FUNC_W'(3);
   localparam logic [FUNC_W-1:0] FN_AND  = FUNC_W'(4);
   localparam logic [FUNC_W-1:0] FN_OR   = FUNC_W'(5);
   localparam logic [FUNC_W-1:0] FN_XOR  = FUNC_W'(6);
   localparam logic [FUNC_W-1:0] FN_SLL  = FUNC_W'(7);
   localparam logic [FUNC_W-1:0] FN_SRL  = FUNC_W'(8);
   localparam logic [FUNC_W-1:0] FN_SRA  = FUNC_W'(9);

   logic [4:0] shamt;
   assign shamt = opb_i[4:0];

   // Opcode decode; the marker value makes bad opcodes visible on the CDB
   always_comb begin
      result_o = XLEN'(32'hfacebeec);
      case (func_i)
         FN_ADD:  result_o = opa_i + opb_i;
         FN_SUB:  result_o = opa_i - opb_i;
         FN_SLT:  result_o = XLEN'($signed(opa_i) < $signed(opb_i));
         FN_SLTU: result_o = XLEN'(opa_i < opb_i);
         FN_AND:  result_o = opa_i & opb_i;
         FN_OR:   result_o = opa_i | opb_i;
         FN_XOR:  result_o = opa_i ^ opb_i;
         FN_SLL:  result_o = opa_i << shamt;
         FN_SRL:  result_o = opa_i >> shamt;
         FN_SRA:  result_o = XLEN'($signed(opa_i) >>> shamt);
         default: ;
      endcase
   end

endmodule

module alu_cdb_sched #(
   parameter int NUM_ALU  = 3,
   parameter int NUM_CDB  = 2,
   parameter int PREG_W   = 6,
   parameter int ROB_W    = 5,
   parameter int XLEN     = 32,
   parameter int ALU_FUNC = 4
) (
   input  logic                         clock_i,
   input  logic                         reset_i,
   input  logic                         flush_i,
   input  logic [NUM_ALU-1:0]           iss_valid_i,
   output logic [NUM_ALU-1:0]           iss_ready_o,
   input  logic [NUM_ALU*XLEN-1:0]      iss_opa_i,
   input  logic [NUM_ALU*XLEN-1:0]      iss_opb_i,
   input  logic [NUM_ALU*ALU_FUNC-1:0]  iss_func_i,
   input  logic [NUM_ALU*PREG_W-1:0]    iss_dest_preg_i,
   input  logic [NUM_ALU*ROB_W-1:0]     iss_rob_idx_i,
   output logic [NUM_CDB-1:0]           cdb_valid_o,
   output logic [NUM_CDB*XLEN-1:0]      cdb_value_o,
   output logic [NUM_CDB*PREG_W-1:0]    cdb_preg_o,
   output logic [NUM_CDB*ROB_W-1:0]     cdb_rob_idx_o
`ifdef ALU_CDB_SCHED_PERF_EN
   ,
   output logic [31:0]                  perf_stall_cycles_o,
   output logic [31:0]                  perf_bcast_count_o
`endif
);

   localparam int RR_W  = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;
   localparam int CDB_W = (NUM_CDB > 1) ? $clog2(NUM_CDB) : 1;

   logic [NUM_ALU-1:0] lane_vld_q;
   logic [NUM_ALU-1:0] lane_vld_d;
   logic [XLEN-1:0]    lane_val_q  [NUM_ALU];
   logic [PREG_W-1:0]  lane_preg_q [NUM_ALU];
   logic [ROB_W-1:0]   lane_rob_q  [NUM_ALU];
   logic [XLEN-1:0]    alu_res     [NUM_ALU];
   logic [RR_W-1:0]    rr_ptr_q;
   logic [RR_W-1:0]    rr_ptr_d;
   logic [NUM_ALU-1:0] grant;
   logic [NUM_ALU-1:0] take;
   logic [NUM_CDB-1:0] port_used;
   logic [RR_W-1:0]    port_lane   [NUM_CDB];
   logic               active;

   // Reset and flush both silence the scheduler for the current cycle
   assign active = reset_i && !flush_i;

   genvar gi;

   generate
      for (gi = 0; gi < NUM_ALU; gi++) begin : g_lane
         alu #(
            .XLEN   (XLEN),
            .FUNC_W (ALU_FUNC)
         ) u_alu (
            .opa_i    (iss_opa_i[gi*XLEN +: XLEN]),
            .opb_i    (iss_opb_i[gi*XLEN +: XLEN]),
            .func_i   (iss_func_i[gi*ALU_FUNC +: ALU_FUNC]),
            .result_o (alu_res[gi])
         );
      end
   endgenerate

   // Round-robin scan from rr_ptr; k-th granted lane goes to CDB port k
   always_comb begin
      int              pos;
      int              n_grant;
      logic [RR_W-1:0] lane;
      grant     = '0;
      port_used = '0;
      rr_ptr_d  = rr_ptr_q;
      n_grant   = 0;
      pos       = 0;
      lane      = '0;
      for (int p = 0; p < NUM_CDB; p++) begin
         port_lane[p] = '0;
      end
      for (int k = 0; k < NUM_ALU; k++) begin
         pos = int'(rr_ptr_q) + k;
         if (pos >= NUM_ALU) begin
            pos = pos - NUM_ALU;
         end
         lane = RR_W'(pos);
         if (active && lane_vld_q[lane] && (n_grant < NUM_CDB)) begin
            grant[lane]                  = 1'b1;
            port_used[CDB_W'(n_grant)]   = 1'b1;
            port_lane[CDB_W'(n_grant)]   = lane;
            n_grant                      = n_grant + 1;
            rr_ptr_d                     = (pos == NUM_ALU - 1) ? '0 : RR_W'(pos + 1);
         end
      end
   end

   // A lane accepts when empty or draining this cycle; capture or drain sets next occupancy
   assign iss_ready_o = {NUM_ALU{active}} & (~lane_vld_q | grant);
   assign take        = iss_valid_i & iss_ready_o;
   assign lane_vld_d  = take | (lane_vld_q & ~grant);

   // Lane occupancy and arbitration pointer; reset and flush both empty the lanes
   always_ff @(posedge clock_i) begin
      if (!reset_i || flush_i) begin
         lane_vld_q <= '0;
         rr_ptr_q   <= '0;
      end else begin
         lane_vld_q <= lane_vld_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   // Result payload capture on issue transfer; occupancy bit qualifies it
   always_ff @(posedge clock_i) begin
      for (int i = 0; i < NUM_ALU; i++) begin
         if (take[i]) begin
            lane_val_q[i]  <= alu_res[i];
            lane_preg_q[i] <= iss_dest_preg_i[i*PREG_W +: PREG_W];
            lane_rob_q[i]  <= iss_rob_idx_i[i*ROB_W +: ROB_W];
         end
      end
   end

   generate
      for (gi = 0; gi < NUM_CDB; gi++) begin : g_cdb
         assign cdb_valid_o[gi]                 = port_used[gi];
         assign cdb_value_o[gi*XLEN +: XLEN]     = port_used[gi] ? lane_val_q[port_lane[gi]]  : '0;
         assign cdb_preg_o[gi*PREG_W +: PREG_W]  = port_used[gi] ? lane_preg_q[port_lane[gi]] : '0;
         assign cdb_rob_idx_o[gi*ROB_W +: ROB_W] = port_used[gi] ? lane_rob_q[port_lane[gi]]  : '0;
      end
   endgenerate

`ifdef ALU_CDB_SCHED_PERF_EN
   logic [31:0] perf_stall_q;
   logic [31:0] perf_bcast_q;

   // Stall and broadcast counters; only reset clears them, both wrap
   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         perf_stall_q <= '0;
         perf_bcast_q <= '0;
      end else begin
         if (|(lane_vld_q & ~grant)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
         perf_bcast_q <= perf_bcast_q + 32'($countones(port_used));
      end
   end

   assign perf_stall_cycles_o = perf_stall_q;
   assign perf_bcast_count_o  = perf_bcast_q;
`endif

endmodule

// File: doc/alu_cdb_sched.md
Name: alu_cdb_sched

Overview:
- Issue-to-writeback scheduler for the integer ALU lanes of the 3-way out-of-order core.
- Accepts up to NUM_ALU issued ALU ops per cycle, one per lane, and evaluates each on its own `alu` instance.
- Holds each result in a one-entry per-lane result register.
- Arbitrates the lanes round-robin onto NUM_CDB common-data-bus ports; back-pressures issue when a lane's result is stuck.

Parameters:
- NUM_ALU, 3, number of ALU lanes / issue slots.
- NUM_CDB, 2, number of CDB broadcast ports available to ALUs (1..NUM_ALU).
- PREG_W, 6, physical register tag width.
- ROB_W, 5, ROB index width.

Ports:
- clock  in  1  system clock; single clock domain, all state on rising edge.
- reset  in  1  synchronous, active-low; 0 = reset.
- flush  in  1  branch-mispredict squash; synchronous.
- iss_valid  in  NUM_ALU  per-lane issue request.
- iss_ready  out  NUM_ALU  per-lane accept; a transfer occurs when valid & ready.
- iss_opa  in  NUM_ALU*XLEN  operand A per lane.
- iss_opb  in  NUM_ALU*XLEN  operand B per lane.
- iss_func  in  NUM_ALU x ALU_FUNC  ALU opcode per lane.
- iss_dest_preg  in  NUM_ALU*PREG_W  destination tag per lane.
- iss_rob_idx  in  NUM_ALU*ROB_W  ROB index per lane.
- cdb_valid  out  NUM_CDB  broadcast valid per port.
- cdb_value  out  NUM_CDB*XLEN  result value.
- cdb_preg  out  NUM_CDB*PREG_W  destination tag.
- cdb_rob_idx  out  NUM_CDB*ROB_W  ROB index.

Behaviour:
- Per lane state: lane_vld, lane_val[XLEN], lane_preg, lane_rob. Global state: rr_ptr (clog2(NUM_ALU) bits).
- Reset (reset==0 at edge): all lane_vld=0, rr_ptr=0.
- While in reset and on the cycle after: cdb_valid=0, cdb_value/preg/rob=0, iss_ready=0 during reset.
- Unused CDB ports always drive valid=0 and all fields 0.
- Result capture: on transfer in lane i at cycle t, `alu` output (combinational from iss_* of lane i) and tags load into lane i; lane_vld=1 at t+1.
- Latency: earliest CDB broadcast is cycle t+1.
- Grant, combinational each cycle: scan lanes rr_ptr, rr_ptr+1, ... mod NUM_ALU.
  - Grant the first min(NUM_CDB, #valid) valid lanes.
  - k-th granted lane in scan order drives CDB port k.
- rr_ptr update: (index of last granted lane + 1) mod NUM_ALU; unchanged if no grant.
- iss_ready[i] = !flush && (!lane_vld[i] || granted[i]). Same-cycle drain+refill allowed: lane granted at t may accept a new op at t, valid at t+1.
- Lane valid, not granted: holds contents, iss_ready[i]=0 (stall). No result is ever dropped or duplicated.
- Issue valid while not ready: no capture; the issuer must hold its request stable.
- Flush:
  - In the flush cycle, cdb_valid forced 0 and iss_ready=0.
  - At the edge, all lane_vld=0 and rr_ptr=0.
  - Flush with reset: reset wins (identical result).
- Reset mid-operation: pending results discarded; no broadcast on the following cycle.
- Arithmetic: delegated to `alu`. SRL/SLL/SRA use opb[4:0]. Unknown func yields XLEN'hfacebeec and is still broadcast.
- NUM_CDB >= NUM_ALU: every valid lane is granted every cycle and iss_ready is never deasserted except during flush/reset.

Optional Feature:
- Macro: ALU_CDB_SCHED_PERF_EN.
- Defined: adds outputs perf_stall_cycles[31:0] and perf_bcast_count[31:0].
  - perf_stall_cycles increments by 1 in any cycle with ≥1 valid, ungranted lane.
  - perf_bcast_count increments by the number of asserted cdb_valid bits.
  - Both clear on reset only (not on flush); both wrap at 2^32.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Single op, lane 0: ADD opa=5, opb=7, preg=12, rob=3 at cycle t -> cycle t+1: cdb_valid=01, port0 value=12, preg=12, rob=3; rr_ptr=1.
- Contention, all 3 lanes, from reset: lane0 SUB 10-3, lane1 SLT -1<1, lane2 SRA 0x80000000>>>4 at t.
  - t+1: port0=7 (lane0), port1=1 (lane1); iss_ready[2]=0.
  - t+2: port0=0xF8000000 (lane2); rr_ptr: 2, then 0.
- Back-to-back: lane0 issues every cycle with 2 CDB ports and other lanes idle -> iss_ready[0] stays 1; one broadcast per cycle; results in order.
- Fairness: all lanes issue continuously for 6 cycles -> each lane broadcasts 4 times. Grant order 0,1 | 2,0 | 1,2 | ...
- Flush: lanes 1, 2 valid, flush=1 -> that cycle cdb_valid=00, iss_ready=000; next cycle cdb_valid=00, rr_ptr=0; a new issue is accepted.
- Reset mid-stall: lane2 pending with reset=0 for 1 cycle -> no broadcast of lane2 afterwards. With ALU_CDB_SCHED_PERF_EN: counters read 0 after reset.
